// File: rtl/coffee_pkg.sv
// Shared definitions for the two-user coffee machine scheduler.
package coffee_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WARM = 2'b01;
  localparam logic [1:0] BREW = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  typedef logic req_idx_t;

  function automatic logic [1:0] onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/coffee_phase_timer.sv
// Phase counter for the warm-up and brew phases, with terminal-count compare
// against a limit chosen by the scheduler each cycle.
module coffee_phase_timer
  import coffee_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tc = (cnt_reg == limit);

endmodule

// File: rtl/coffee_sched.sv
// Round-robin arbiter for the shared coffee machine: grants one requester,
// sequences warm-up then brew on the machine inputs, and pulses done.
module coffee_sched
  import coffee_pkg::*;
#(
  parameter int WARM_CYCLES = 4,
  parameter int BREW_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       cancel,
  output logic       on,
  output logic       gen,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic [1:0] state_reg
);

  logic [1:0]       state_next;
  req_idx_t         owner_reg, owner_next;
  req_idx_t         last_reg, last_next;
  logic             cnt_clear, cnt_en, tc;
  logic [CNT_W-1:0] limit;
  logic [1:0]       owner_hot;

  assign limit = (state_reg == BREW) ? CNT_W'(BREW_CYCLES - 1) : CNT_W'(WARM_CYCLES - 1);

  coffee_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .limit (limit),
    .tc    (tc)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester that was not served last wins.
          owner_next = (req == 2'b11) ? ~last_reg : req[1];
          cnt_clear  = 1'b1;
          state_next = WARM;
        end
      end
      WARM, BREW: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
          last_next  = owner_reg;
        end else if (tc) begin
          cnt_clear  = 1'b1;
          state_next = (state_reg == WARM) ? BREW : DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign on        = (state_reg == WARM) || (state_reg == BREW);
  assign gen       = (state_reg == BREW);
  assign owner_hot = onehot(owner_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign grant[gi] = busy && owner_hot[gi];
      assign done[gi]  = (state_reg == DONE) && owner_hot[gi];
    end
  endgenerate

endmodule

// File: tb/tb_coffee_sched.sv
// Bench for coffee_sched: directed scenarios plus random traffic, every cycle
// checked against a service-timeline model of the scheduler.
module tb_coffee_sched;

  localparam int W = 4;
  localparam int B = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic       cancel = 1'b0;
  logic       on, gen, busy;
  logic [1:0] grant, done, state_reg;

  coffee_sched #(.WARM_CYCLES(W), .BREW_CYCLES(B), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .cancel    (cancel),
    .on        (on),
    .gen       (gen),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .state_reg (state_reg)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: a service is a timeline of elapsed cycles since the grant.
  bit m_busy = 1'b0;
  bit m_owner = 1'b0;
  bit m_last = 1'b1;
  int m_el = 0;

  int         done_cyc[$];
  logic [1:0] done_val[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare_outputs;
    logic [1:0] e_state, e_grant, e_done;
    logic       e_on, e_gen;
    e_state = 2'b00; e_grant = 2'b00; e_done = 2'b00; e_on = 1'b0; e_gen = 1'b0;
    if (m_busy) begin
      e_grant = m_owner ? 2'b10 : 2'b01;
      if (m_el < W) begin
        e_state = 2'b01; e_on = 1'b1;
      end else if (m_el < W + B) begin
        e_state = 2'b10; e_on = 1'b1; e_gen = 1'b1;
      end else begin
        e_state = 2'b11; e_done = e_grant;
      end
    end
    check("state", 32'(state_reg), 32'(e_state));
    check("on",    32'(on),        32'(e_on));
    check("gen",   32'(gen),       32'(e_gen));
    check("grant", 32'(grant),     32'(e_grant));
    check("done",  32'(done),      32'(e_done));
    check("busy",  32'(busy),      32'(m_busy));
  endtask

  task automatic model_step(input logic [1:0] r, input logic c, input logic rst);
    if (!rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      if (r != 2'b00) begin
        m_busy  = 1'b1;
        m_el    = 0;
        m_owner = (r == 2'b11) ? !m_last : r[1];
      end
    end else if (m_el == W + B) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (c) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else begin
      m_el++;
    end
  endtask

  task automatic cycle(input logic [1:0] r, input logic c, input logic rst);
    req = r; cancel = c; reset = rst;
    @(posedge clock);
    model_step(r, c, rst);
    @(negedge clock);
    cyc++;
    compare_outputs();
    if (done != 2'b00) begin
      done_cyc.push_back(cyc);
      done_val.push_back(done);
      $display("cycle %0d: done=%b", cyc, done);
    end
  endtask

  task automatic clear_log;
    done_cyc.delete();
    done_val.delete();
  endtask

  int t0;

  initial begin
    @(negedge clock);

    // Reset with both requests asserted
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);

    // Single request
    clear_log(); t0 = cyc;
    for (int i = 0; i < 13; i++) cycle(2'b01, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    check("single_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("single_lat", done_cyc[0] - t0, 13);

    // Contention after reset
    cycle(2'b00, 1'b0, 1'b0);
    clear_log(); t0 = cyc;
    for (int i = 0; i < 42; i++) cycle(2'b11, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    check("cont_ndone", done_val.size(), 3);
    if (done_val.size() == 3) begin
      check("cont_d0", 32'(done_val[0]), 32'(2'b01));
      check("cont_d1", 32'(done_val[1]), 32'(2'b10));
      check("cont_d2", 32'(done_val[2]), 32'(2'b01));
      check("cont_gap1", done_cyc[1] - done_cyc[0], 14);
      check("cont_gap2", done_cyc[2] - done_cyc[1], 14);
    end

    // Cancel on third brew cycle, then a tie
    cycle(2'b00, 1'b0, 1'b0);
    clear_log();
    for (int i = 0; i < 7; i++) cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b10, 1'b1, 1'b1);
    check("cancel_on", 32'(on), 32'(1'b0));
    cycle(2'b11, 1'b0, 1'b1);
    check("cancel_grant", 32'(grant), 32'(2'b01));
    for (int i = 0; i < 13; i++) cycle(2'b11, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    check("cancel_ndone", done_val.size(), 1);

    // Reset during brew, then a tie must go to requester 0
    for (int i = 0; i < 8; i++) cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b10, 1'b0, 1'b0);
    check("rst_busy", 32'(busy), 32'(1'b0));
    cycle(2'b11, 1'b0, 1'b1);
    check("rst_grant", 32'(grant), 32'(2'b01));

    // Drop request mid-warm
    cycle(2'b00, 1'b0, 1'b0);
    clear_log(); t0 = cyc;
    for (int i = 0; i < 3; i++) cycle(2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(2'b00, 1'b0, 1'b1);
    check("drop_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) begin
      check("drop_lat", done_cyc[0] - t0, 13);
      check("drop_val", 32'(done_val[0]), 32'(2'b10));
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
            !($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coffee_sched.md
# coffee_sched

Two-user scheduler for the single coffee machine. Accepts brew requests from two requesters and grants the machine to one at a time with round-robin fairness. Drives the machine's `on`/`gen` inputs through a timed warm-up then brew sequence, and pulses a per-requester `done` on completion. Sits between the user-button debouncers and the coffee machine FSM, which stays unmodified.

## Interface
Parameters:
- `WARM_CYCLES`, default 4: cycles `on`=1, `gen`=0 before brewing; must be ≥1.
- `BREW_CYCLES`, default 8: cycles `on`=1, `gen`=1; must be ≥1.
- `CNT_W`, default 4: phase counter width; must satisfy 2^CNT_W ≥ max(WARM_CYCLES, BREW_CYCLES).

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  2  level brew request per requester; held until that requester's `done`.
- `cancel`  in  1  abort the current service.
- `on`  out  1  to machine `on`.
- `gen`  out  1  to machine `gen`.
- `grant`  out  2  one-hot owner of the machine, 0 when idle.
- `done`  out  2  one-cycle completion pulse to the served requester.
- `busy`  out  1  high in any state other than IDLE.
- `state_reg`  out  2  current state, for debug/LEDs.

## Operation
- States: IDLE=00, WARM=01, BREW=10, DONE=11. Outputs are Moore-decoded from the state plus the latched owner.
- IDLE:
  - `on`=`gen`=0, `grant`=0.
  - If `req`≠0: latch the owner, clear the counter, go to WARM.
  - Single request: that requester wins.
  - Both requesting: the requester ≠ `last` wins.
- WARM:
  - `on`=1, `gen`=0, `grant`=onehot(owner).
  - The counter increments each cycle.
  - When cnt==WARM_CYCLES−1: clear cnt, go to BREW.
- BREW:
  - `on`=1, `gen`=1.
  - When cnt==BREW_CYCLES−1: go to DONE.
- DONE:
  - `on`=`gen`=0, `grant` still onehot(owner), `done`[owner]=1.
  - Set `last`←owner, go to IDLE.
- `cancel`:
  - Sampled 1 in WARM or BREW: next state is IDLE, cnt cleared, `last`←owner, no `done` pulse.
  - Ignored in IDLE and DONE.
- Dropping `req`[owner] mid-service does not abort. The service completes and `done` still pulses.
- A request arriving while busy waits and is evaluated in the next IDLE cycle.
- `last` resets to 1, so requester 0 wins the first tie.
- Counter arithmetic is unsigned CNT_W-bit and never wraps in legal configurations.

## Timing
- Reset (`reset`==0 at a rising edge):
  - Next cycle: state=IDLE, cnt=0, `last`=1.
  - `on`=`gen`=`busy`=0, `grant`=`done`=0, `state_reg`=00.
  - Reset overrides everything, including mid-service; no `done` is emitted.
- `req` sampled in IDLE at edge t: WARM is entered at t+1.
  - `on` is high for exactly WARM_CYCLES+BREW_CYCLES cycles.
  - `gen` is high for exactly the last BREW_CYCLES of those cycles.
  - DONE is at t+1+WARM_CYCLES+BREW_CYCLES.
- At least one IDLE cycle separates consecutive services: DONE → IDLE → WARM.
- With both `req` held, grants alternate 0,1,0,1…

## Structure
- Package `coffee_pkg`:
  - state encoding constants IDLE/WARM/BREW/DONE (2 bits);
  - requester-index typedef.
- Sub-module `coffee_phase_timer`:
  - CNT_W counter with `clear`, `en` and terminal-count compare against a runtime limit (WARM_CYCLES−1 or BREW_CYCLES−1, selected by state).
  - Everything else lives in `coffee_sched`: state register, owner/last registers, next-state logic.

## Test plan
All scenarios use WARM_CYCLES=4, BREW_CYCLES=8.
- Reset: hold `reset`=0 for 2 cycles with `req`=11 → all outputs 0, `state_reg`=00 throughout.
- Single request: `req`=01 pulsed then held → `grant`=01 from next cycle; `on`=1 for 12 cycles, `gen`=1 for the last 8; `done`=01 for one cycle at 13 cycles after the sample.
- Contention: `req`=11 held → services granted 0, 1, 0; `done` pulses 01, 10, 01, each 14 cycles apart.
- Cancel: `req`=10, assert `cancel` for one cycle on the 3rd BREW cycle → IDLE next cycle, `on`=`gen`=0, no `done`. A following `req`=11 grants requester 0.
- Mid-service: `reset`=0 in BREW → IDLE with all outputs 0, `last`=1. Separately, dropping `req` mid-WARM still yields `done` at the normal cycle.
